// File: rtl/led_ctrl_pkg.sv
// Shared types and defaults for the LED shifter front-end controller.
package led_ctrl_pkg;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_GAP   = 1'b1
    } arb_state_t;

    localparam logic GNT_B0 = 1'b0;
    localparam logic GNT_B1 = 1'b1;

    localparam int DEF_DEB_CYCLES = 4;
    localparam int DEF_MIN_GAP    = 1;

endpackage

// File: rtl/led_shifter_ctrl_debouncer.sv
// Two-flop synchronizer followed by a stability filter: a level is accepted
// only after it has differed from the current stable value for DEB_CYCLES cycles.
module debouncer
    import led_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int CNT_W      = $clog2(DEB_CYCLES) + 1
) (
    input  logic clk,
    input  logic sync_reset,
    input  logic raw,
    output logic stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            // any return to the stable level restarts the qualification window
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_shifter_ctrl.sv
// Front-end for led_shifter_3: debounces buttons/switches and arbitrates the
// single write path between the two buttons with a minimum inter-write gap.
//
//   state    | meaning
//   ST_READY | may grant a pending press this cycle
//   ST_GAP   | counting down forced idle cycles after a grant, no grants
module led_shifter_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int CNT_W      = $clog2(DEB_CYCLES) + 1,
    parameter int MIN_GAP    = DEF_MIN_GAP
) (
    input  logic clk,
    input  logic sync_reset,
    input  logic button0_raw,
    input  logic button1_raw,
    input  logic show_parity_raw,
    input  logic show_history_raw,
    output logic button0_re,
    output logic button1_re,
    output logic show_parity_deb,
    output logic show_history_deb,
    output logic overrun
);

    localparam int               GAP_W    = $clog2(MIN_GAP + 2);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    logic b0_stable;
    logic b1_stable;
    logic par_stable;
    logic hist_stable;

    logic b0_stable_d;
    logic b1_stable_d;
    logic rise0;
    logic rise1;

    logic pend0;
    logic pend1;
    logic pend0_next;
    logic pend1_next;
    logic overrun_next;

    arb_state_t       state;
    arb_state_t       state_next;
    logic [GAP_W-1:0] gap;
    logic [GAP_W-1:0] gap_next;
    logic             last_grant;
    logic             last_grant_next;
    logic             gnt0;
    logic             gnt1;

    debouncer #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_b0 (
        .clk        (clk),
        .sync_reset (sync_reset),
        .raw        (button0_raw),
        .stable     (b0_stable)
    );

    debouncer #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_b1 (
        .clk        (clk),
        .sync_reset (sync_reset),
        .raw        (button1_raw),
        .stable     (b1_stable)
    );

    debouncer #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_par (
        .clk        (clk),
        .sync_reset (sync_reset),
        .raw        (show_parity_raw),
        .stable     (par_stable)
    );

    debouncer #(.DEB_CYCLES(DEB_CYCLES), .CNT_W(CNT_W)) u_deb_hist (
        .clk        (clk),
        .sync_reset (sync_reset),
        .raw        (show_history_raw),
        .stable     (hist_stable)
    );

    assign rise0 = b0_stable & ~b0_stable_d;
    assign rise1 = b1_stable & ~b1_stable_d;

    // History display takes priority over parity display.
    assign show_history_deb = hist_stable;
    assign show_parity_deb  = par_stable & ~hist_stable;

    always_comb begin
        state_next      = state;
        gap_next        = gap;
        last_grant_next = last_grant;
        gnt0            = 1'b0;
        gnt1            = 1'b0;

        case (state)
            ST_READY: begin
                if (pend0 || pend1) begin
                    // round-robin on a tie: serve whoever was not served last
                    if (pend0 && (!pend1 || (last_grant == GNT_B1))) begin
                        gnt0            = 1'b1;
                        last_grant_next = GNT_B0;
                    end else begin
                        gnt1            = 1'b1;
                        last_grant_next = GNT_B1;
                    end
                    gap_next = GAP_LOAD;
                    if (MIN_GAP > 0) begin
                        state_next = ST_GAP;
                    end
                end
            end
            ST_GAP: begin
                if (gap <= GAP_ONE) begin
                    gap_next   = '0;
                    state_next = ST_READY;
                end else begin
                    gap_next = gap - 1'b1;
                end
            end
            default: begin
                state_next = ST_READY;
                gap_next   = '0;
            end
        endcase

        // A press arriving in the cycle its own pend is granted stays queued.
        pend0_next   = (pend0 & ~gnt0) | rise0;
        pend1_next   = (pend1 & ~gnt1) | rise1;
        overrun_next = (rise0 & pend0 & ~gnt0) | (rise1 & pend1 & ~gnt1);
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state      <= ST_READY;
            gap        <= '0;
            last_grant <= GNT_B1;
        end else begin
            state      <= state_next;
            gap        <= gap_next;
            last_grant <= last_grant_next;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            b0_stable_d <= 1'b0;
            b1_stable_d <= 1'b0;
            pend0       <= 1'b0;
            pend1       <= 1'b0;
            button0_re  <= 1'b0;
            button1_re  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            b0_stable_d <= b0_stable;
            b1_stable_d <= b1_stable;
            pend0       <= pend0_next;
            pend1       <= pend1_next;
            button0_re  <= gnt0;
            button1_re  <= gnt1;
            overrun     <= overrun_next;
        end
    end

endmodule

// File: tb/tb_led_shifter_ctrl.sv
// Directed bench for led_shifter_ctrl: a per-cycle vector table for a single
// press and the display modes, plus hand sequences for arbitration and reset.
module tb_led_shifter_ctrl;

    logic clk;
    logic sync_reset;
    logic button0_raw;
    logic button1_raw;
    logic show_parity_raw;
    logic show_history_raw;
    logic button0_re;
    logic button1_re;
    logic show_parity_deb;
    logic show_history_deb;
    logic overrun;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int ovr_cnt  = 0;
    int both_cnt = 0;
    int pulse_cyc[$];
    int pulse_btn[$];

    led_shifter_ctrl #(
        .DEB_CYCLES (4),
        .CNT_W      (3),
        .MIN_GAP    (1)
    ) dut (
        .clk              (clk),
        .sync_reset       (sync_reset),
        .button0_raw      (button0_raw),
        .button1_raw      (button1_raw),
        .show_parity_raw  (show_parity_raw),
        .show_history_raw (show_history_raw),
        .button0_re       (button0_re),
        .button1_re       (button1_re),
        .show_parity_deb  (show_parity_deb),
        .show_history_deb (show_history_deb),
        .overrun          (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp = {button0_re, button1_re, show_parity_deb, show_history_deb, overrun}
    typedef struct {
        logic       rst;
        logic       b0;
        logic       b1;
        logic       p;
        logic       h;
        logic [4:0] exp;
    } vec_t;

    localparam int NVEC = 75;
    vec_t vecs [NVEC];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (button0_re) begin
            pulse_cyc.push_back(cyc);
            pulse_btn.push_back(0);
        end
        if (button1_re) begin
            pulse_cyc.push_back(cyc);
            pulse_btn.push_back(1);
        end
        if (overrun) ovr_cnt++;
        if (button0_re && button1_re) both_cnt++;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        pulse_cyc.delete();
        pulse_btn.delete();
    endtask

    task automatic check_pulse(input string name, input int idx, input int btn, input int at);
        if (idx < pulse_cyc.size()) begin
            check({name, "_btn"}, pulse_btn[idx], btn);
            check({name, "_cyc"}, pulse_cyc[idx], at);
        end else begin
            check({name, "_present"}, pulse_cyc.size(), idx + 1);
        end
    endtask

    function automatic logic [4:0] outs();
        return {button0_re, button1_re, show_parity_deb, show_history_deb, overrun};
    endfunction

    task automatic do_reset(input string name);
        sync_reset       = 1'b1;
        button0_raw      = 1'b0;
        button1_raw      = 1'b0;
        show_parity_raw  = 1'b0;
        show_history_raw = 1'b0;
        tick();
        tick();
        check({name, "_reset_outs"}, outs(), 5'b0);
        sync_reset = 1'b0;
    endtask

    int seq [10] = '{0, 0, 0, 1, 1, 0, 0, 1, 1, 0};

    initial begin
        int t0;
        int min_sp;

        sync_reset       = 1'b1;
        button0_raw      = 1'b0;
        button1_raw      = 1'b0;
        show_parity_raw  = 1'b0;
        show_history_raw = 1'b0;

        // vector i: inputs set before edge i+1, outputs checked just after it
        for (int i = 0; i < NVEC; i++) vecs[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'b0};
        vecs[0].rst = 1'b1;
        vecs[1].rst = 1'b1;
        for (int i = 2; i <= 21; i++) vecs[i].b0 = 1'b1;
        vecs[9].exp[4] = 1'b1;                              // press edge 1 at vec 2, pulse at edge 8
        for (int i = 32; i <= 64; i++) vecs[i].p = 1'b1;
        for (int i = 42; i <= 54; i++) vecs[i].h = 1'b1;
        for (int i = 37; i <= 46; i++) vecs[i].exp[2] = 1'b1;
        for (int i = 47; i <= 59; i++) vecs[i].exp[1] = 1'b1;
        for (int i = 60; i <= 69; i++) vecs[i].exp[2] = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            sync_reset       = vecs[i].rst;
            button0_raw      = vecs[i].b0;
            button1_raw      = vecs[i].b1;
            show_parity_raw  = vecs[i].p;
            show_history_raw = vecs[i].h;
            tick();
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Glitch shorter than the debounce window, then a just-long-enough pulse
        do_reset("glitch");
        clear_log();
        button1_raw = 1'b1;
        repeat (3) tick();
        button1_raw = 1'b0;
        repeat (12) tick();
        check("glitch_pulses", pulse_cyc.size(), 0);
        clear_log();
        t0 = cyc;
        button1_raw = 1'b1;
        repeat (4) tick();
        button1_raw = 1'b0;
        repeat (16) tick();
        check("pulse4_count", pulse_cyc.size(), 1);
        check_pulse("pulse4", 0, 1, t0 + 8);

        // Tie right after reset: button0 first, button1 two cycles later
        do_reset("tie");
        clear_log();
        t0 = cyc;
        button0_raw = 1'b1;
        button1_raw = 1'b1;
        repeat (20) tick();
        button0_raw = 1'b0;
        button1_raw = 1'b0;
        repeat (12) tick();
        check("tie1_count", pulse_cyc.size(), 2);
        check_pulse("tie1_first", 0, 0, t0 + 8);
        check_pulse("tie1_second", 1, 1, t0 + 10);

        // Lone button0 press leaves last_grant on button0, so the next tie favours button1
        clear_log();
        t0 = cyc;
        button0_raw = 1'b1;
        repeat (6) tick();
        button0_raw = 1'b0;
        repeat (12) tick();
        check("solo0_count", pulse_cyc.size(), 1);
        check_pulse("solo0", 0, 0, t0 + 8);
        clear_log();
        t0 = cyc;
        button0_raw = 1'b1;
        button1_raw = 1'b1;
        repeat (20) tick();
        button0_raw = 1'b0;
        button1_raw = 1'b0;
        repeat (12) tick();
        check("tie2_count", pulse_cyc.size(), 2);
        check_pulse("tie2_first", 0, 1, t0 + 8);
        check_pulse("tie2_second", 1, 0, t0 + 10);

        // Press sequence, 6 cycles held and 6 idle per press
        do_reset("seq");
        clear_log();
        t0 = cyc;
        for (int k = 0; k < 10; k++) begin
            if (seq[k] == 0) button0_raw = 1'b1;
            else button1_raw = 1'b1;
            repeat (6) tick();
            button0_raw = 1'b0;
            button1_raw = 1'b0;
            repeat (6) tick();
        end
        repeat (12) tick();
        check("seq_count", pulse_cyc.size(), 10);
        for (int k = 0; k < 10; k++) begin
            check_pulse($sformatf("seq%0d", k), k, seq[k], t0 + 12 * k + 8);
        end
        min_sp = 1000;
        for (int k = 1; k < pulse_cyc.size(); k++) begin
            if (pulse_cyc[k] - pulse_cyc[k-1] < min_sp) min_sp = pulse_cyc[k] - pulse_cyc[k-1];
        end
        check("seq_min_spacing_ok", (min_sp >= 2), 1);

        // Reset while in GAP with pend1 set, button1 still held
        do_reset("gap_rst");
        clear_log();
        t0 = cyc;
        button0_raw = 1'b1;
        button1_raw = 1'b1;
        repeat (8) tick();
        check("gap_rst_grant0", button0_re, 1'b1);
        sync_reset  = 1'b1;
        button0_raw = 1'b0;
        tick();
        check("gap_rst_outs", outs(), 5'b0);
        sync_reset = 1'b0;
        clear_log();
        t0 = cyc;
        repeat (20) tick();
        check("gap_rst_count", pulse_cyc.size(), 1);
        check_pulse("gap_rst_b1", 0, 1, t0 + 8);

        check("overrun_total", ovr_cnt, 0);
        check("both_total", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
